// File: rtl/ctl_fetch_rx.sv
// ----------------------------------------------------------------------------
// ctl_fetch_rx
//
// Clocked receiver for a 4-phase req/ack bundled-data handshake that comes from
// the asynchronous fetch controller. req_i passes through a multi-flop
// synchronizer. Each completed request writes data_i into a small FIFO, and
// ack_o reports the capture. Buffered words go to the decode stage through a
// valid/ready interface. When the FIFO is full, ack_o is held low so the
// sender waits.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rst_ni   : synchronous active-low reset
//   req_i    : asynchronous 4-phase request
//   data_i   : bundled data, stable while req_i=1 until ack_o=1
//   ack_o    : 4-phase acknowledge, driven straight from a flop
//   instr_o  : FIFO head word, meaningful only while valid_o=1
//   valid_o  : FIFO holds at least one word
//   ready_i  : consumer takes the head word when valid_o && ready_i
//   level_o  : FIFO occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module ctl_fetch_rx #(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [DW-1:0]              data_i,
  output logic                       ack_o,
  output logic [DW-1:0]              instr_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    IDLE     = 2'd1,
    ACK      = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   ack_next;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;

  logic [DW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  // ---- req_i synchronizer ---------------------------------------------------
  // The flops reset to 1. After a reset, the FSM therefore treats the request
  // as still high. This remains true until a real low has travelled through
  // the synchronizer, so a request left over from before reset is never
  // captured.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_sync <= '1;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  // ---- FIFO status ----------------------------------------------------------
  // The full flag uses the current level only. A pop in the same cycle cannot
  // make room for a push, so the push waits for the next edge.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;
  assign level_o = level;
  assign instr_o = mem[rd_ptr];

  // ---- handshake FSM: next state --------------------------------------------
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      RST_WAIT: begin
        if (!req_s) state_next = IDLE;
      end
      IDLE: begin
        // With req_s high and the FIFO full, the FSM stays in IDLE with ack
        // low. The capture happens once space appears.
        if (req_s && !full) begin
          push       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!req_s) state_next = IDLE;
      end
      default: state_next = RST_WAIT;
    endcase
    // ack_o is registered from the next state. The sender therefore sees one
    // clean flop output with no combinational path behind it.
    ack_next = (state_next == ACK);
  end

  // ---- handshake FSM: state and acknowledge registers -----------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= RST_WAIT;
      ack_o <= 1'b0;
    end else begin
      state <= state_next;
      ack_o <= ack_next;
    end
  end

  // ---- FIFO storage ---------------------------------------------------------
  // Storage is not reset. After a reset the pointers and the level make any
  // old contents unreachable.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // ---- FIFO pointers and occupancy ------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_fetch_rx.sv
module tb_ctl_fetch_rx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [DW-1:0] data;
  logic          ack;
  logic [DW-1:0] instr;
  logic          valid;
  logic          ready;
  logic [2:0]    level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ideal queue, the request seen through a SYNC-cycle
  // delay, and the protocol state of the acknowledge.
  logic [DW-1:0] mq[$];
  bit            dl[$];
  bit            m_ack;
  bit            m_armed;
  int            dut_max_level;

  ctl_fetch_rx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .data_i  (data),
    .ack_o   (ack),
    .instr_o (instr),
    .valid_o (valid),
    .ready_i (ready),
    .level_o (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    dl.delete();
    for (int i = 0; i < SYNC; i++) dl.push_back(1'b1);
    m_ack   = 1'b0;
    m_armed = 1'b0;
  endtask

  // One clock edge. The model advances with the inputs present at the edge,
  // then the DUT outputs are compared 1 time unit later.
  task automatic step();
    bit rs, m_push, m_pop;
    rs     = dl[0];
    m_pop  = (mq.size() > 0) && ready;
    m_push = m_armed && !m_ack && rs && (mq.size() < DEPTH);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(data);
      if (!m_armed)          m_armed = !rs;
      else if (m_push)       m_ack   = 1'b1;
      else if (m_ack && !rs) m_ack   = 1'b0;
      void'(dl.pop_front());
      dl.push_back(req);
    end
    #1;
    if (int'(level) > dut_max_level) dut_max_level = int'(level);
    chk("ack", {31'b0, ack}, {31'b0, m_ack});
    chk("valid", {31'b0, valid}, {31'b0, (mq.size() > 0)});
    chk("level", {29'b0, level}, mq.size());
    if (mq.size() > 0) chk("instr", instr, mq[0]);
  endtask

  task automatic wait_ack(input logic val, input string tag, output int n);
    n = 0;
    while (ack !== val && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'b0, ack}, {31'b0, val});
  endtask

  task automatic handshake(input logic [DW-1:0] d);
    int n;
    req  = 1'b1;
    data = d;
    wait_ack(1'b1, "hs_ack_rise", n);
    req = 1'b0;
    wait_ack(1'b0, "hs_ack_fall", n);
  endtask

  initial begin
    int n;
    logic [DW-1:0] d;
    model_reset();
    dut_max_level = 0;
    rst_n = 1'b0;
    req   = 1'b0;
    data  = '0;
    ready = 1'b0;

    // T1: reset, single handshake, latency
    step();
    step();
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_level", {29'b0, level}, 32'd0);
    rst_n = 1'b1;
    repeat (4) step();
    req  = 1'b1;
    data = 32'hDEADBEEF;
    wait_ack(1'b1, "t1_ack_rise", n);
    chk("t1_rise_latency", n, SYNC + 1);
    chk("t1_instr", instr, 32'hDEADBEEF);
    chk("t1_level", {29'b0, level}, 32'd1);
    req = 1'b0;
    wait_ack(1'b0, "t1_ack_fall", n);
    chk("t1_fall_latency", n, SYNC + 1);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // T2: fill to full, fifth request stalls until one pop
    for (int i = 1; i <= 4; i++) handshake(DW'(i));
    chk("t2_level_full", {29'b0, level}, 32'd4);
    req  = 1'b1;
    data = 32'd5;
    repeat (10) step();
    chk("t2_stall_ack", {31'b0, ack}, 32'd0);
    chk("t2_head_before_pop", instr, 32'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    wait_ack(1'b1, "t2_ack5_rise", n);
    req = 1'b0;
    wait_ack(1'b0, "t2_ack5_fall", n);
    chk("t2_final_level", {29'b0, level}, 32'd4);
    chk("t2_final_head", instr, 32'd2);

    // T3: streaming with ready high; the pointers wrap twice
    ready = 1'b1;
    repeat (6) step();
    dut_max_level = 0;
    for (int i = 0; i < 8; i++) handshake(32'hA0 + DW'(i));
    repeat (3) step();
    chk("t3_max_level_le1", {31'b0, (dut_max_level <= 1)}, 32'd1);
    chk("t3_drained", {29'b0, level}, 32'd0);

    // T4: reset while in ACK with level 2
    ready = 1'b0;
    handshake($urandom);
    req  = 1'b1;
    data = $urandom;
    wait_ack(1'b1, "t4_ack_rise", n);
    chk("t4_level_pre", {29'b0, level}, 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t4_rst_ack", {31'b0, ack}, 32'd0);
    chk("t4_rst_valid", {31'b0, valid}, 32'd0);
    chk("t4_rst_level", {29'b0, level}, 32'd0);
    repeat (10) step();
    chk("t4_no_capture", {29'b0, level}, 32'd0);
    req = 1'b0;
    repeat (3) step();
    d = $urandom;
    handshake(d);
    chk("t4_new_level", {29'b0, level}, 32'd1);
    chk("t4_new_word", instr, d);

    // T5: simultaneous push and pop at level 2
    handshake($urandom);
    chk("t5_level_pre", {29'b0, level}, 32'd2);
    req  = 1'b1;
    data = $urandom;
    step();
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t5_ack", {31'b0, ack}, 32'd1);
    chk("t5_level_same", {29'b0, level}, 32'd2);
    req = 1'b0;
    wait_ack(1'b0, "t5_ack_fall", n);
    ready = 1'b1;
    repeat (3) step();
    chk("t5_drained", {29'b0, level}, 32'd0);

    // T6: ready high with an empty FIFO
    repeat (10) step();
    chk("t6_level", {29'b0, level}, 32'd0);
    chk("t6_valid", {31'b0, valid}, 32'd0);
    ready = 1'b0;
    d = $urandom;
    handshake(d);
    chk("t6_word_after", instr, d);

    // Randomized traffic: a well-behaved sender and a random consumer
    for (int c = 0; c < 400; c++) begin
      if (!req && !ack && ($urandom_range(0, 1) == 1)) begin
        req  = 1'b1;
        data = $urandom;
      end else if (req && ack) begin
        req = 1'b0;
      end
      if (c < 150) ready = ($urandom_range(0, 3) == 0);
      else         ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
